harmonic_weight_mixer: RTL and testbench

//  Consumer of the 2-bit harmonic weight produced by the weight-button cycler.

---
 rtl/harmonic_weight_mixer.sv | 135 +++++++++++++
 tb/tb_harmonic_weight_mixer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/harmonic_weight_mixer.sv
// rtl/harmonic_weight_mixer.sv - weighted harmonic mixer with click-free crossfade on profile change
module harmonic_weight_mixer #(
    parameter int SW        = 16,
    parameter int XFADE_LEN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    weight,
    input  logic          sample_valid,
    input  logic [SW-1:0] f_in,
    input  logic [SW-1:0] h2_in,
    input  logic [SW-1:0] h3_in,
    output logic [SW-1:0] mix_out,
    output logic          mix_valid,
    output logic          xfading
);

    // Two guard bits keep the profile sums and the crossfade blend from wrapping.
    localparam int EW = SW + 2;
    localparam int CW = 4;
    localparam logic signed [EW-1:0] MAX_V = {3'b000, {(SW-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {3'b111, {(SW-1){1'b0}}};

    logic        [1:0]    active;
    logic        [1:0]    old;
    logic        [CW-1:0] count;
    logic        [1:0]    active_nxt;
    logic        [1:0]    old_nxt;
    logic        [CW-1:0] count_nxt;
    logic        [1:0]    w_dec;

    logic signed [EW-1:0] f_ext;
    logic signed [EW-1:0] h2_ext;
    logic signed [EW-1:0] h3_ext;

    logic signed [EW-1:0] p_old;
    logic signed [EW-1:0] p_act;
    logic                 s1_xf;
    logic                 s1_valid;
    logic signed [EW-1:0] blend;
    logic        [SW-1:0] clamped;

    // Floor shifts on sign-extended operands; the reserved code falls back to the fundamental.
    function automatic logic signed [EW-1:0] profile(
        input logic [1:0]           sel,
        input logic signed [EW-1:0] f,
        input logic signed [EW-1:0] h2,
        input logic signed [EW-1:0] h3
    );
        case (sel)
            2'd1:    profile = (f >>> 1) + (h2 >>> 2) + (h3 >>> 2);
            2'd2:    profile = (f >>> 2) + (h2 >>> 1) + (h3 >>> 2);
            default: profile = f;
        endcase
    endfunction

    assign f_ext  = {{2{f_in[SW-1]}},  f_in};
    assign h2_ext = {{2{h2_in[SW-1]}}, h2_in};
    assign h3_ext = {{2{h3_in[SW-1]}}, h3_in};
    assign w_dec  = (weight == 2'd3) ? 2'd0 : weight;

    // Weight capture: a change restarts the fade from whatever profile is currently active.
    always_comb begin
        active_nxt = active;
        old_nxt    = old;
        count_nxt  = count;
        if (sample_valid) begin
            if (w_dec != active) begin
                old_nxt    = active;
                active_nxt = w_dec;
                count_nxt  = CW'(XFADE_LEN);
            end else if (count != '0) begin
                count_nxt = count - 1'b1;
            end
        end
    end

    // Profile selection state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 2'd0;
            old    <= 2'd0;
            count  <= '0;
        end else begin
            active <= active_nxt;
            old    <= old_nxt;
            count  <= count_nxt;
        end
    end

    // Stage 1: evaluate both profiles and whether this sample is inside the fade.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_old    <= '0;
            p_act    <= '0;
            s1_xf    <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= sample_valid;
            if (sample_valid) begin
                p_old <= profile(old_nxt, f_ext, h2_ext, h3_ext);
                p_act <= profile(active_nxt, f_ext, h2_ext, h3_ext);
                s1_xf <= (count_nxt != '0);
            end
        end
    end

    // Stage 2 combine: equal-weight blend during the fade, then saturate to the sample range.
    always_comb begin
        blend = s1_xf ? ((p_old >>> 1) + (p_act >>> 1)) : p_act;
        if (blend > MAX_V) begin
            clamped = MAX_V[SW-1:0];
        end else if (blend < MIN_V) begin
            clamped = MIN_V[SW-1:0];
        end else begin
            clamped = blend[SW-1:0];
        end
    end

    // Stage 2 register: output and its fade flag hold between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mix_out   <= '0;
            mix_valid <= 1'b0;
            xfading   <= 1'b0;
        end else begin
            mix_valid <= s1_valid;
            if (s1_valid) begin
                mix_out <= clamped;
                xfading <= s1_xf;
            end
        end
    end

endmodule

// File: tb/tb_harmonic_weight_mixer.sv
// tb/tb_harmonic_weight_mixer.sv - directed self-checking bench for harmonic_weight_mixer
module tb_harmonic_weight_mixer;

    logic        clk;
    logic        reset;
    logic [1:0]  weight;
    logic        sample_valid;
    logic [15:0] f_in;
    logic [15:0] h2_in;
    logic [15:0] h3_in;
    logic [15:0] mix_out;
    logic        mix_valid;
    logic        xfading;

    int errors = 0;
    int checks = 0;

    harmonic_weight_mixer #(.SW(16), .XFADE_LEN(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .weight       (weight),
        .sample_valid (sample_valid),
        .f_in         (f_in),
        .h2_in        (h2_in),
        .h3_in        (h3_in),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .xfading      (xfading)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One strobe; result must appear exactly two cycles later, not one.
    task automatic do_sample(input string tag, input logic [1:0] w, input int exp_out, input int exp_xf);
        @(negedge clk);
        weight       = w;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        weight       = 2'd0;
        check({tag, "_early_valid"}, int'(mix_valid), 0);
        @(negedge clk);
        check({tag, "_valid"}, int'(mix_valid), 1);
        check({tag, "_out"}, int'($signed(mix_out)), exp_out);
        check({tag, "_xf"}, int'(xfading), exp_xf);
    endtask

    initial begin
        int pulses;
        int first_idx;
        reset        = 1'b0;
        weight       = 2'd0;
        sample_valid = 1'b0;
        f_in         = 16'sd1000;
        h2_in        = 16'sd400;
        h3_in        = -16'sd200;
        repeat (3) @(negedge clk);
        check("rst_out", int'(mix_out), 0);
        check("rst_valid", int'(mix_valid), 0);
        check("rst_xf", int'(xfading), 0);
        reset = 1'b1;

        for (int i = 0; i < 3; i++) do_sample("p0", 2'd0, 1000, 0);

        for (int i = 0; i < 4; i++) do_sample("fade01", 2'd1, 775, 1);
        for (int i = 0; i < 2; i++) do_sample("p1", 2'd1, 550, 0);

        for (int i = 0; i < 4; i++) do_sample("fade12", 2'd2, 475, 1);
        do_sample("p2", 2'd2, 400, 0);

        for (int i = 0; i < 4; i++) do_sample("fade20_w3", 2'd3, 700, 1);
        do_sample("p0_w3", 2'd3, 1000, 0);

        do_sample("midfade_01", 2'd1, 775, 1);
        for (int i = 0; i < 4; i++) do_sample("midfade_12", 2'd2, 475, 1);
        do_sample("midfade_done", 2'd2, 400, 0);

        // Back-to-back: eight consecutive strobes, pulses counted over a bounded window.
        pulses    = 0;
        first_idx = -1;
        weight    = 2'd2;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (mix_valid) begin
                if (first_idx < 0) first_idx = i;
                pulses++;
                check("b2b_out", int'($signed(mix_out)), 400);
            end
            sample_valid = (i < 8);
        end
        check("b2b_pulses", pulses, 8);
        check("b2b_latency", first_idx, 2);

        // Reset one cycle after a strobe: that sample must never emerge.
        @(negedge clk);
        weight       = 2'd1;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        reset        = 1'b0;
        #1;
        check("midrst_out_now", int'(mix_out), 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mix_valid) pulses++;
            if (i == 1) reset = 1'b1;
        end
        check("midrst_pulses", pulses, 0);
        check("midrst_out", int'(mix_out), 0);

        // Negative full-scale through profile 1 (active restarted at 0 by reset).
        f_in  = -16'sd32767;
        h2_in = -16'sd32767;
        h3_in = -16'sd32767;
        do_sample("neg_fade", 2'd1, -32768, 1);
        for (int i = 0; i < 4; i++) do_sample("neg_p1", 2'd1, -32768, (i < 3) ? 1 : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
